ram: RTL and testbench

- Single-port synchronous static RAM with one bidirectional tri-state data bus and chip-select, write-enable and output-enable controls.
- Serves as a generic byte-wide (by default) memory block on a shared bus; it drives the bus only during an enabled read.
- Depth is 2^ADDR_WIDTH words of DATA_WIDTH bits; one clock domain.

---
 rtl/ram.sv | 42 ++++
 tb/tb_ram.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ram.sv
// Single-port synchronous SRAM with a shared tri-state data bus.
// Writes and reads land on the rising edge; the bus driver enable is purely combinational.
module ram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_en;
  logic                  rd_en;
  logic                  drive_en;

  assign wr_en    = cs & we;
  assign rd_en    = cs & ~we;
  // rst_n in the enable releases the bus the instant reset asserts
  assign drive_en = rst_n & cs & ~we & oe;

  // Array has no reset so contents survive rst_n; writes still honour it.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[addr] <= data;
  end

  // Read register updates even with oe low so a read can be prefetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end

  assign data = drive_en ? rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: write/read sweeps, bus gating, deselect protection,
// top-address write-then-read and asynchronous reset with retained contents.
module tb_ram;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        cs;
  logic        we;
  logic        oe;
  logic        bus_en;
  logic [7:0]  bus_drv;
  wire  [7:0]  data;

  int checks;
  int failures;

  logic [7:0] vals [0:15];
  logic [7:0] zz;

  assign data = bus_en ? bus_drv : 8'bz;

  ram #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .data (data),
    .cs   (cs),
    .we   (we),
    .oe   (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    zz       = 8'bz;
    vals[0]  = 8'h24; vals[1]  = 8'h81; vals[2]  = 8'h09; vals[3]  = 8'h63;
    vals[4]  = 8'h0D; vals[5]  = 8'h8D; vals[6]  = 8'h65; vals[7]  = 8'h12;
    vals[8]  = 8'h01; vals[9]  = 8'h0D; vals[10] = 8'h76; vals[11] = 8'h3D;
    vals[12] = 8'hED; vals[13] = 8'h8C; vals[14] = 8'hF9; vals[15] = 8'hC6;

    rst_n = 1'b0; cs = 1'b1; we = 1'b0; oe = 1'b1;
    addr = '0; bus_en = 1'b0; bus_drv = '0;
    #12;
    chk("reset_hiz", data, zz);
    @(negedge clk);
    rst_n = 1'b1;
    cs = 1'b0;
    #1;
    chk("idle_hiz", data, zz);

    // write sweep: bench owns the bus, any DUT drive would show as X
    for (int i = 0; i < 16; i++) begin
      cs = 1'b1; we = 1'b1; oe = 1'b0; addr = 16'(i);
      bus_en = 1'b1; bus_drv = vals[i];
      edge1();
      chk($sformatf("wr_bus_%0d", i), data, vals[i]);
    end
    bus_en = 1'b0;
    #1;
    chk("wr_release_hiz", data, zz);

    // enabling the driver before any read edge shows the reset-cleared rdata
    we = 1'b0; oe = 1'b1; addr = 16'd0;
    #1;
    chk("rd_pre_rdata0", data, 8'h00);

    for (int i = 0; i < 16; i++) begin
      addr = 16'(i);
      edge1();
      chk($sformatf("rd_%0d", i), data, vals[i]);
    end

    // output gating around a read of addr 3
    addr = 16'd3;
    edge1();
    chk("gate_rd3", data, 8'h63);
    oe = 1'b0; #1; chk("gate_oe0", data, zz);
    oe = 1'b1; #1; chk("gate_oe1", data, 8'h63);
    we = 1'b1; #1; chk("gate_we1", data, zz);
    we = 1'b0; #1; chk("gate_we0", data, 8'h63);
    cs = 1'b0; #1; chk("gate_cs0", data, zz);
    cs = 1'b1; #1; chk("gate_restore", data, 8'h63);

    // deselected write must not land
    @(negedge clk);
    cs = 1'b0; we = 1'b1; addr = 16'd2; bus_en = 1'b1; bus_drv = 8'hFF;
    edge1();
    bus_en = 1'b0; cs = 1'b1; we = 1'b0; oe = 1'b1;
    edge1();
    chk("desel_protect", data, 8'h09);

    // write-then-read on consecutive edges at the top address
    we = 1'b1; oe = 1'b0; addr = 16'hFFFF; bus_en = 1'b1; bus_drv = 8'hA5;
    edge1();
    bus_en = 1'b0; we = 1'b0; oe = 1'b1;
    edge1();
    chk("wr_rd_top", data, 8'hA5);

    // prefetch with oe low, then enable
    oe = 1'b0; addr = 16'd1;
    edge1();
    chk("prefetch_hiz", data, zz);
    oe = 1'b1; #1;
    chk("prefetch_drive", data, 8'h81);

    // async reset mid-read; a write attempt during reset must be blocked
    addr = 16'd5;
    edge1();
    chk("pre_reset_rd", data, 8'h8D);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_hiz", data, zz);
    we = 1'b1; addr = 16'd0; bus_en = 1'b1; bus_drv = 8'h55;
    edge1();
    #2;
    bus_en = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_reset_rdata0", data, 8'h00);
    edge1();
    chk("retain_addr0", data, 8'h24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
